// File: rtl/timer_pkg.sv
// Shared types and constants for tick_timer: the run state and the mode encoding.
package timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// Programmable down-counter advanced by prescaler ticks; one-shot or auto-reload,
// with a one-cycle expiry pulse and a sticky interrupt flag.
module tick_timer
   import timer_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_50,
   input  logic         rst,
   input  logic         tick,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [W-1:0] load_val,
   input  logic         irq_ack,
   output logic [W-1:0] cnt_val,
   output logic         busy,
   output logic         expired,
   output logic         irq
);

   state_t       state;
   logic [W-1:0] reload;
   logic         mode;
   logic         do_stop;
   logic         do_start;
   logic         do_expire;

   // NOTE: combinational decode gets a default for every signal first so no latch is inferred.
   always_comb begin
      do_stop   = 1'b0;
      do_start  = 1'b0;
      do_expire = 1'b0;
      if (state == RUN && stop) begin
         do_stop = 1'b1;
      end else if (start) begin
         do_start = 1'b1;
      end else if (state == RUN && tick && cnt_val <= W'(1)) begin
         // A count of 0 expires like 1, so the counter never wraps.
         do_expire = 1'b1;
      end
   end

   // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state   <= IDLE;
         cnt_val <= '0;
         reload  <= '0;
         mode    <= MODE_ONESHOT;
         expired <= 1'b0;
         irq     <= 1'b0;
      end else begin
         expired <= do_expire;
         if (do_stop) begin
            state <= IDLE;
         end else if (do_start) begin
            reload  <= load_val;
            cnt_val <= load_val;
            mode    <= periodic;
            state   <= RUN;
         end else if (do_expire) begin
            if (mode == MODE_PERIODIC) begin
               cnt_val <= reload;
            end else begin
               cnt_val <= '0;
               state   <= IDLE;
            end
         end else if (state == RUN && tick) begin
            cnt_val <= cnt_val - W'(1);
         end

         if (do_expire) begin
            irq <= 1'b1;
         end else if (irq_ack) begin
            irq <= 1'b0;
         end
      end
   end

   // state is itself a register, so busy carries no combinational path from inputs.
   assign busy = (state == RUN);

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: a per-cycle behavioural model compared every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_tick_timer;

   localparam int W = 8;

   logic         clk_50 = 1'b0;
   logic         rst = 1'b1;
   logic         tick = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         periodic = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         irq_ack = 1'b0;
   logic [W-1:0] cnt_val;
   logic         busy;
   logic         expired;
   logic         irq;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   tick_timer #(.W(W)) dut (
      .clk_50   (clk_50),
      .rst      (rst),
      .tick     (tick),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .load_val (load_val),
      .irq_ack  (irq_ack),
      .cnt_val  (cnt_val),
      .busy     (busy),
      .expired  (expired),
      .irq      (irq)
   );

   always #10 clk_50 = ~clk_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining ticks, running flag, remembered period and mode.
   int m_rem = 0, m_reload = 0;
   bit m_run = 0, m_per = 0, m_exp = 0, m_irq = 0;

   always @(posedge clk_50) begin
      if (rst) begin
         m_rem = 0; m_reload = 0; m_run = 0; m_per = 0; m_exp = 0; m_irq = 0;
      end else begin
         m_exp = 0;
         if (m_run && stop) begin
            m_run = 0;
         end else if (start) begin
            m_reload = int'(load_val);
            m_rem    = int'(load_val);
            m_per    = periodic;
            m_run    = 1;
         end else if (m_run && tick) begin
            if (m_rem <= 1) begin
               m_exp = 1;
               m_rem = m_per ? m_reload : 0;
               m_run = m_per;
            end else begin
               m_rem = m_rem - 1;
            end
         end
         if (m_exp) m_irq = 1;
         else if (irq_ack) m_irq = 0;
      end
   end

   always @(negedge clk_50) begin
      if (chk_en) begin
         check("model_cnt", 32'(cnt_val), 32'(m_rem));
         check("model_busy", 32'(busy), 32'(m_run));
         check("model_expired", 32'(expired), 32'(m_exp));
         check("model_irq", 32'(irq), 32'(m_irq));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] v, input logic per, input logic with_tick);
      load_val = v; periodic = per; start = 1'b1; tick = with_tick;
      step(1);
      start = 1'b0; tick = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
   endtask

   logic [6:0] exp_hist;
   int         exp_at;

   initial begin
      // Reset with random inputs on the other pins.
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick = 1'($urandom); start = 1'($urandom); stop = 1'($urandom);
         periodic = 1'($urandom); load_val = W'($urandom); irq_ack = 1'($urandom);
         step(1);
      end
      tick = 0; start = 0; stop = 0; periodic = 0; load_val = '0; irq_ack = 0;
      chk_en = 1'b1;
      check("rst_cnt", 32'(cnt_val), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_expired", 32'(expired), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      step(2);

      // One-shot, load 3, ticks every 10 cycles.
      do_start(8'd3, 1'b0, 1'b0);
      check("os_load_cnt", 32'(cnt_val), 32'd3);
      check("os_load_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         step(9);
         do_tick();
         check("os_cnt", 32'(cnt_val), (i < 3) ? 32'(3 - i) : 32'd0);
         check("os_expired", 32'(expired), (i == 3) ? 32'd1 : 32'd0);
      end
      check("os_irq", 32'(irq), 32'd1);
      check("os_busy", 32'(busy), 32'd0);

      // Periodic, load 2, seven back-to-back-spaced ticks.
      do_start(8'd2, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(2);
         do_tick();
         exp_hist[i] = expired;
      end
      check("per_expiries", 32'(exp_hist), 32'b0101010);
      check("per_cnt", 32'(cnt_val), 32'd1);
      check("per_busy", 32'(busy), 32'd1);

      // Stop and restart.
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      check("ack_irq", 32'(irq), 32'd0);
      do_start(8'd5, 1'b0, 1'b0);
      do_tick(); step(1); do_tick();
      check("stop_pre_cnt", 32'(cnt_val), 32'd3);
      stop = 1'b1; tick = 1'b1; step(1); stop = 1'b0; tick = 1'b0;
      check("stop_cnt", 32'(cnt_val), 32'd3);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_expired", 32'(expired), 32'd0);
      stop = 1'b1; step(1); stop = 1'b0;
      check("stop_idle_cnt", 32'(cnt_val), 32'd3);
      do_start(8'd4, 1'b0, 1'b1);
      check("restart_cnt", 32'(cnt_val), 32'd4);
      check("restart_busy", 32'(busy), 32'd1);

      // irq handshake: ack coincident with expiry loses to the set.
      for (int i = 0; i < 3; i++) begin step(1); do_tick(); end
      check("hs_cnt", 32'(cnt_val), 32'd1);
      tick = 1'b1; irq_ack = 1'b1; step(1); tick = 1'b0; irq_ack = 1'b0;
      check("hs_expired", 32'(expired), 32'd1);
      check("hs_irq_set_wins", 32'(irq), 32'd1);
      step(2);
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      check("hs_irq_cleared", 32'(irq), 32'd0);

      // Zero load expires on the first tick.
      do_start(8'd0, 1'b0, 1'b0);
      step(1);
      do_tick();
      check("zero_expired", 32'(expired), 32'd1);
      check("zero_cnt", 32'(cnt_val), 32'd0);
      check("zero_busy", 32'(busy), 32'd0);

      // Prescaler-driven run: one tick every 10 clocks, load 3 -> expiry 30 clocks after start.
      do_start(8'd3, 1'b0, 1'b0);
      exp_at = -1;
      for (int c = 1; c <= 200; c++) begin
         tick = (c % 10 == 0);
         step(1);
         if (expired) begin
            exp_at = c;
            break;
         end
      end
      tick = 1'b0;
      check("presc_expiry_clocks", 32'(exp_at), 32'd30);

      step(3);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
